// File: rtl/camera_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : camera_seq_ctrl
// Brief    : Parametrised frame sequencer for the pixel-array camera.
//            Runs ERASE -> EXPOSE -> per-row READ -> DONE, one frame per
//            init pulse or back-to-back in continuous mode. Owns the
//            user-adjustable exposure time.
// Options  : define CAM_ABORT_EN to add the abort input (mid-frame abort).
// Revision : 1.0 - initial release
// ============================================================================
module camera_seq_ctrl #(
    parameter int EXP_W     = 5,
    parameter int EXP_MIN   = 2,
    parameter int EXP_MAX   = 30,
    parameter int EXP_RST   = 15,
    parameter int N_ROWS    = 2,
    parameter int ERASE_CYC = 1,
    parameter int ADC_CYC   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              exp_increase,
    input  logic              exp_decrease,
    input  logic              mode_cont,
`ifdef CAM_ABORT_EN
    input  logic              abort,
`endif
    output logic [N_ROWS-1:0] nre,
    output logic              adc,
    output logic              expose,
    output logic              erase,
    output logic              busy,
    output logic              frame_done,
    output logic [EXP_W-1:0]  exp_time
);

    // One shared cycle counter covers erase, exposure and per-row read phases
    localparam int c_cnt_top = (EXP_MAX - 1 > ADC_CYC + 1) ?
                               ((EXP_MAX - 1 > ERASE_CYC - 1) ? EXP_MAX - 1 : ERASE_CYC - 1) :
                               ((ADC_CYC + 1 > ERASE_CYC - 1) ? ADC_CYC + 1 : ERASE_CYC - 1);
    localparam int c_cnt_raw = $clog2(c_cnt_top + 1);
    localparam int c_cnt_w   = (c_cnt_raw > EXP_W) ? c_cnt_raw : EXP_W;
    localparam int c_row_w   = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

    localparam logic [N_ROWS-1:0] c_nre_lsb  = N_ROWS'(1);
    localparam logic [N_ROWS-1:0] c_nre_idle = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ERASE  = 3'd1,
        S_EXPOSE = 3'd2,
        S_READ   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_row_w-1:0]  r_row;
    logic [N_ROWS-1:0]   r_nre;
    logic                r_adc;
    logic                r_expose;
    logic                r_erase;
    logic                r_busy;
    logic                r_frame_done;
    logic [EXP_W-1:0]    r_exp;

    logic                w_abort;
    logic [c_cnt_w-1:0]  w_exp_last;
    logic [c_row_w-1:0]  w_row_nxt;

`ifdef CAM_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Last exposure cycle index and next row index, used by the sequencer
    assign w_exp_last = c_cnt_w'(r_exp) - c_cnt_w'(1);
    assign w_row_nxt  = r_row + c_row_w'(1);

    // Frame sequencer: state, counters, exposure setting and all outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_row        <= '0;
            r_nre        <= c_nre_idle;
            r_adc        <= 1'b0;
            r_expose     <= 1'b0;
            r_erase      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_exp        <= EXP_W'(EXP_RST);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (init) begin
                        // exposure is frozen from the start edge onward
                        r_state <= S_ERASE;
                        r_erase <= 1'b1;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end else if (exp_increase && !exp_decrease) begin
                        if (r_exp < EXP_W'(EXP_MAX))
                            r_exp <= r_exp + EXP_W'(1);
                    end else if (exp_decrease && !exp_increase) begin
                        if (r_exp > EXP_W'(EXP_MIN))
                            r_exp <= r_exp - EXP_W'(1);
                    end
                end

                S_ERASE: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                        r_erase <= 1'b0;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_w'(ERASE_CYC - 1)) begin
                        r_state  <= S_EXPOSE;
                        r_erase  <= 1'b0;
                        r_expose <= 1'b1;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end

                S_EXPOSE: begin
                    if (w_abort) begin
                        r_state  <= S_IDLE;
                        r_expose <= 1'b0;
                        r_busy   <= 1'b0;
                        r_cnt    <= '0;
                    end else if (r_cnt == w_exp_last) begin
                        r_state  <= S_READ;
                        r_expose <= 1'b0;
                        r_row    <= '0;
                        r_nre    <= ~c_nre_lsb;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end

                S_READ: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                        r_nre   <= c_nre_idle;
                        r_adc   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_row   <= '0;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_w'(ADC_CYC + 1)) begin
                        // row window finished; adc is already low here
                        r_cnt <= '0;
                        if (r_row == c_row_w'(N_ROWS - 1)) begin
                            r_state      <= S_DONE;
                            r_nre        <= c_nre_idle;
                            r_frame_done <= 1'b1;
                            r_row        <= '0;
                        end else begin
                            r_row <= w_row_nxt;
                            r_nre <= ~(c_nre_lsb << w_row_nxt);
                        end
                    end else begin
                        // adc is high on window cycles 1..ADC_CYC (0-based)
                        r_cnt <= r_cnt + c_cnt_w'(1);
                        r_adc <= (r_cnt < c_cnt_w'(ADC_CYC));
                    end
                end

                S_DONE: begin
                    r_frame_done <= 1'b0;
                    r_cnt        <= '0;
                    if (mode_cont) begin
                        r_state <= S_ERASE;
                        r_erase <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_cnt        <= '0;
                    r_row        <= '0;
                    r_nre        <= c_nre_idle;
                    r_adc        <= 1'b0;
                    r_expose     <= 1'b0;
                    r_erase      <= 1'b0;
                    r_busy       <= 1'b0;
                    r_frame_done <= 1'b0;
                end
            endcase
        end
    end

    assign nre        = r_nre;
    assign adc        = r_adc;
    assign expose     = r_expose;
    assign erase      = r_erase;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign exp_time   = r_exp;

endmodule
`default_nettype wire
